// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The slave side is the loader itself. The master side drives the byte
// stream and observes the memory writes and the run/error status.
interface imem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] words_loaded;
  logic        cpu_run;
  logic        error;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output words_loaded,
    output cpu_run,
    output error
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  words_loaded,
    input  cpu_run,
    input  error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Frame format: CNT_HI, CNT_LO, 4*N payload bytes, checksum byte.
// Payload bytes are packed big-endian into 32-bit words. Each word is written
// starting at BASE_ADDR. The checksum is the 8-bit wrapping sum of the payload
// bytes. A good frame raises cpu_run. An oversize count or a bad checksum
// raises error. Both flags are sticky until reset.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic         clock,
  input  logic         reset_n,
  imem_loader_if.slave bus
);

  // The word count is 16 bits wide, so a 17-bit compare covers every legal DEPTH.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Wrapping 8-bit accumulation of a payload byte into the running checksum.
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    logic [8:0] full;
    full = {1'b0, acc} + {1'b0, b};
    return full[7:0];
  endfunction

  // Big-endian packing: the earliest byte ends up in bits [31:24].
  function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

  // Byte address of word index idx relative to BASE_ADDR.
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return BASE_ADDR + {14'd0, idx, 2'b00};
  endfunction

  state_t      state_q;
  logic [7:0]  cnt_hi_q;
  logic [15:0] count_q;
  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;
  logic [7:0]  sum_q;
  logic        wr_en_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic [15:0] words_loaded_q;
  logic        cpu_run_q;
  logic        error_q;

  logic        accepting;
  logic        xfer;
  logic [15:0] count_d;
  logic [31:0] word_d;
  logic [7:0]  sum_d;
  logic [15:0] words_loaded_d;

  // Ready is forced low while reset is held, so no byte is taken during reset.
  // Otherwise ready depends only on the state, so stalls cannot cause side effects.
  always_comb begin
    accepting      = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
    xfer           = reset_n && accepting && bus.in_valid;
    count_d        = {cnt_hi_q, bus.in_data};
    word_d         = pack_byte(word_q, bus.in_data);
    sum_d          = sum_add(sum_q, bus.in_data);
    words_loaded_d = words_loaded_q + 16'd1;
  end

  // Frame FSM with registered write strobe, address, data and status flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_CNT_HI;
      cnt_hi_q       <= 8'd0;
      count_q        <= 16'd0;
      byte_idx_q     <= 2'd0;
      word_q         <= 32'd0;
      sum_q          <= 8'd0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= BASE_ADDR;
      wr_data_q      <= 32'd0;
      words_loaded_q <= 16'd0;
      cpu_run_q      <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (xfer) begin
        case (state_q)
          S_CNT_HI: begin
            cnt_hi_q <= bus.in_data;
            state_q  <= S_CNT_LO;
          end
          S_CNT_LO: begin
            count_q    <= count_d;
            byte_idx_q <= 2'd0;
            if ({1'b0, count_d} > DEPTH_W) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else if (count_d == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            sum_q      <= sum_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              // The address uses the count from before this write.
              // The count then advances in the same cycle as the strobe.
              wr_en_q        <= 1'b1;
              wr_data_q      <= word_d;
              wr_addr_q      <= word_addr(words_loaded_q);
              words_loaded_q <= words_loaded_d;
              if (words_loaded_d == count_q) begin
                state_q <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (bus.in_data == sum_q) begin
              state_q   <= S_DONE;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign bus.in_ready     = reset_n && accepting;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.words_loaded = words_loaded_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected memory writes are queued as
// payload is driven, and then popped as the loader strobes wr_en.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;
  logic [63:0] exp_q[$];

  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(BASE), .DEPTH(1024)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (reset_n && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", bus.wr_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, e[63:32]);
        check("wr_data", bus.wr_data, e[31:0]);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_data = 8'($urandom);
        @(posedge clock); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clock); #1;
    end else begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_payload(input logic [7:0] p[$], input bit gaps);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < p.size(); i++) begin
      w = {w[23:0], p[i]};
      if ((i % 4) == 3) exp_q.push_back({BASE + 32'(4 * (i / 4)), w});
      send_byte(p[i], gaps);
    end
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] p[$],
                            input logic [7:0] chk, input bit gaps);
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    send_payload(p, gaps);
    send_byte(chk, gaps);
  endtask

  task automatic apply_reset(input bit full_check);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    if (full_check) begin
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_wr_addr", bus.wr_addr, BASE);
      check("rst_wr_data", bus.wr_data, 32'd0);
      check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
    end
    check("rst_words", 32'(bus.words_loaded), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
  endtask

  // Status one cycle after the final byte of a frame.
  task automatic check_status(input string tag, input bit run, input bit err,
                              input logic [15:0] words);
    @(negedge clock);
    check({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'(run));
    check({tag, "_error"}, 32'(bus.error), 32'(err));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_words"}, 32'(bus.words_loaded), 32'(words));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [7:0] p1[$];
    logic [7:0] pff[$];
    logic [7:0] none[$];
    logic [7:0] part[$];
    logic [7:0] p2[$];
    n_checks     = 0;
    n_pass       = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    p1   = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    pff  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    none = {};
    part = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    p2   = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    @(posedge clock); #1;

    // Good two-word frame at full rate.
    apply_reset(1'b1);
    send_frame(16'd2, p1, 8'h37, 1'b0);
    check_status("good", 1'b1, 1'b0, 16'd2);

    // Same payload with a wrong checksum: writes still happen, CPU held.
    apply_reset(1'b0);
    send_frame(16'd2, p1, 8'h36, 1'b0);
    check_status("badchk", 1'b0, 1'b1, 16'd2);

    // Empty frames.
    apply_reset(1'b0);
    send_frame(16'd0, none, 8'h00, 1'b0);
    check_status("n0_good", 1'b1, 1'b0, 16'd0);
    apply_reset(1'b0);
    send_frame(16'd0, none, 8'h01, 1'b0);
    check_status("n0_bad", 1'b0, 1'b1, 16'd0);

    // Oversize count: rejected right after CNT_LO, payload refused.
    apply_reset(1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clock);
    check("over_error", 32'(bus.error), 32'd1);
    check("over_cpu_run", 32'(bus.cpu_run), 32'd0);
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("over_refuse", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check("over_words", 32'(bus.words_loaded), 32'd0);

    // Random gaps must not change the writes or the result.
    apply_reset(1'b0);
    send_frame(16'd2, p1, 8'h37, 1'b1);
    check_status("gaps", 1'b1, 1'b0, 16'd2);

    // Checksum wrap: 4 * 0xFF = 0x3FC, so the byte is 0xFC.
    apply_reset(1'b0);
    send_frame(16'd1, pff, 8'hFC, 1'b0);
    check_status("wrap", 1'b1, 1'b0, 16'd1);

    // Reset mid-frame after five payload bytes, then a fresh frame.
    apply_reset(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_payload(part, 1'b0);
    @(posedge clock); #1;
    check("mid_words_before", 32'(bus.words_loaded), 32'd1);
    apply_reset(1'b0);
    check("mid_wr_addr", bus.wr_addr, BASE);
    send_frame(16'd1, p2, 8'hDE + 8'hAD + 8'hBE + 8'hEF, 1'b1);
    check_status("after_mid", 1'b1, 1'b0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end
endmodule
